// File: rtl/io_bus_ctrl.sv
// Bridges the RisKy1 core I/O port onto NUM_DEV memory-mapped peripheral slots:
// decode, one access at a time, device handshake with timeout, single-cycle ack/fault back to the core.
module io_bus_ctrl #(
    parameter int          A_SZ    = 32,
    parameter int          D_SZ    = 32,
    parameter int          NUM_DEV = 4,
    parameter int          DEV_LSB = 12,
    parameter logic [3:0]  REGION  = 4'hF,
    parameter int          TIMEOUT = 255
) (
    input  logic                    clk_in,
    input  logic                    reset_in,
    input  logic                    io_req,
    input  logic [A_SZ-1:0]         io_addr,
    input  logic                    io_rd,
    input  logic                    io_wr,
    input  logic [D_SZ-1:0]         io_wr_data,
    output logic                    io_ack,
    output logic                    io_ack_fault,
    output logic [D_SZ-1:0]         io_rd_data,
    output logic [NUM_DEV-1:0]      dev_sel,
    output logic [A_SZ-1:0]         dev_addr,
    output logic                    dev_rd,
    output logic                    dev_wr,
    output logic [D_SZ-1:0]         dev_wr_data,
    input  logic [NUM_DEV-1:0]      dev_ack,
    input  logic [NUM_DEV-1:0]      dev_fault,
    input  logic [NUM_DEV*D_SZ-1:0] dev_rd_data
);

    localparam int IDX_W = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP,
        ST_FAULT,
        ST_WAIT
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_DEV-1:0]  dev_sel_q, dev_sel_d;
    logic [A_SZ-1:0]     dev_addr_q, dev_addr_d;
    logic                dev_rd_q, dev_rd_d;
    logic                dev_wr_q, dev_wr_d;
    logic [D_SZ-1:0]     dev_wr_data_q, dev_wr_data_d;
    logic [D_SZ-1:0]     io_rd_data_q, io_rd_data_d;

    logic [IDX_W-1:0]    req_idx;
    logic [NUM_DEV-1:0]  req_onehot;
    logic                req_ok;
    logic                sel_ack;
    logic                sel_fault;
    logic [D_SZ-1:0]     sel_rd_data;

    // With a single slot there is no index field in the address.
    generate
        if (NUM_DEV > 1) begin : g_idx
            assign req_idx = io_addr[DEV_LSB +: IDX_W];
        end else begin : g_idx_single
            assign req_idx = '0;
        end
    endgenerate

    assign req_onehot = NUM_DEV'(1) << req_idx;
    assign req_ok     = (io_addr[A_SZ-1 -: 4] == REGION)
                      && (io_rd != io_wr)
                      && ({{(32-IDX_W){1'b0}}, req_idx} < 32'(NUM_DEV));

    // Only the slot we selected may finish the access.
    assign sel_ack   = |(dev_ack & dev_sel_q);
    assign sel_fault = |(dev_fault & dev_sel_q);

    always_comb begin
        sel_rd_data = '0;
        for (int k = 0; k < NUM_DEV; k++) begin
            if (dev_sel_q[k]) begin
                sel_rd_data = sel_rd_data | dev_rd_data[k*D_SZ +: D_SZ];
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            dev_sel_q     <= '0;
            dev_addr_q    <= '0;
            dev_rd_q      <= 1'b0;
            dev_wr_q      <= 1'b0;
            dev_wr_data_q <= '0;
            io_rd_data_q  <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            dev_sel_q     <= dev_sel_d;
            dev_addr_q    <= dev_addr_d;
            dev_rd_q      <= dev_rd_d;
            dev_wr_q      <= dev_wr_d;
            dev_wr_data_q <= dev_wr_data_d;
            io_rd_data_q  <= io_rd_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (io_req) begin
                    state_d = req_ok ? ST_ACCESS : ST_FAULT;
                end
            end
            ST_ACCESS: begin
                if (!io_req) begin
                    state_d = ST_IDLE;
                end else if (sel_fault) begin
                    state_d = ST_FAULT;
                end else if (sel_ack) begin
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_FAULT;
                end
            end
            ST_RESP:  state_d = ST_WAIT;
            ST_FAULT: state_d = ST_WAIT;
            ST_WAIT:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Device-side registers are only non-zero while an access is in flight.
    always_comb begin
        cnt_d         = cnt_q;
        dev_sel_d     = '0;
        dev_addr_d    = '0;
        dev_rd_d      = 1'b0;
        dev_wr_d      = 1'b0;
        dev_wr_data_d = '0;
        io_rd_data_d  = io_rd_data_q;
        if (state_q == ST_IDLE && state_d == ST_ACCESS) begin
            cnt_d         = '0;
            dev_sel_d     = req_onehot;
            dev_addr_d    = io_addr;
            dev_rd_d      = io_rd;
            dev_wr_d      = io_wr;
            dev_wr_data_d = io_wr_data;
        end else if (state_q == ST_ACCESS && state_d == ST_ACCESS) begin
            dev_sel_d     = dev_sel_q;
            dev_addr_d    = dev_addr_q;
            dev_rd_d      = dev_rd_q;
            dev_wr_d      = dev_wr_q;
            dev_wr_data_d = dev_wr_data_q;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (state_q == ST_ACCESS && state_d == ST_RESP) begin
            io_rd_data_d = dev_rd_q ? sel_rd_data : '0;
        end
        if (state_d == ST_FAULT) begin
            io_rd_data_d = '0;
        end
    end

    always_comb begin
        io_ack       = 1'b0;
        io_ack_fault = 1'b0;
        case (state_q)
            ST_RESP:  io_ack       = 1'b1;
            ST_FAULT: io_ack_fault = 1'b1;
            default: ;
        endcase
    end

    assign io_rd_data  = io_rd_data_q;
    assign dev_sel     = dev_sel_q;
    assign dev_addr    = dev_addr_q;
    assign dev_rd      = dev_rd_q;
    assign dev_wr      = dev_wr_q;
    assign dev_wr_data = dev_wr_data_q;

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Scoreboard bench for io_bus_ctrl: a driver plays core and device, a monitor pops expected responses.
module tb_io_bus_ctrl;

    localparam int NUM_DEV = 4;
    localparam int TIMEOUT = 8;
    localparam int K_ACK = 0, K_FAULT = 1, K_BOTH = 2, K_SILENT = 3;

    logic                    clk_in = 1'b0;
    logic                    reset_in = 1'b0;
    logic                    io_req = 1'b0;
    logic [31:0]             io_addr = '0;
    logic                    io_rd = 1'b0;
    logic                    io_wr = 1'b0;
    logic [31:0]             io_wr_data = '0;
    logic                    io_ack;
    logic                    io_ack_fault;
    logic [31:0]             io_rd_data;
    logic [NUM_DEV-1:0]      dev_sel;
    logic [31:0]             dev_addr;
    logic                    dev_rd;
    logic                    dev_wr;
    logic [31:0]             dev_wr_data;
    logic [NUM_DEV-1:0]      dev_ack = '0;
    logic [NUM_DEV-1:0]      dev_fault = '0;
    logic [NUM_DEV*32-1:0]   dev_rd_data = '0;

    io_bus_ctrl #(
        .A_SZ(32), .D_SZ(32), .NUM_DEV(NUM_DEV), .DEV_LSB(12),
        .REGION(4'hF), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_in(clk_in), .reset_in(reset_in),
        .io_req(io_req), .io_addr(io_addr), .io_rd(io_rd), .io_wr(io_wr),
        .io_wr_data(io_wr_data), .io_ack(io_ack), .io_ack_fault(io_ack_fault),
        .io_rd_data(io_rd_data), .dev_sel(dev_sel), .dev_addr(dev_addr),
        .dev_rd(dev_rd), .dev_wr(dev_wr), .dev_wr_data(dev_wr_data),
        .dev_ack(dev_ack), .dev_fault(dev_fault), .dev_rd_data(dev_rd_data)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct {
        int          exp_cyc;
        bit          fault;
        bit          chk_data;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_tests = 0;
    int          n_fail = 0;
    bit          hold_chk = 0;
    logic [31:0] hold_val = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every response the DUT presents must match the oldest expectation.
    always @(negedge clk_in) begin
        if (reset_in) begin
            chk("excl_onehot", 64'({io_ack && io_ack_fault, !$onehot0(dev_sel)}), 64'(0));
            if (hold_chk) begin
                chk("rd_data_hold", 64'(io_rd_data), 64'(hold_val));
                hold_chk = 0;
            end
            if (io_ack || io_ack_fault) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_resp: got ack=%0b fault=%0b, expected none (t=%0t)",
                             io_ack, io_ack_fault, $time);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("resp_cycle", 64'(cyc), 64'(mon_e.exp_cyc));
                    chk("resp_kind", 64'({io_ack, io_ack_fault}), 64'({!mon_e.fault, mon_e.fault}));
                    if (mon_e.chk_data) begin
                        chk("resp_rd_data", 64'(io_rd_data), 64'(mon_e.data));
                        hold_chk = 1;
                        hold_val = mon_e.data;
                    end
                end
            end
        end
    end

    // Drives one core request plus the device behaviour; the expectation comes from the address rules.
    task automatic do_txn(input logic [31:0] addr, input logic rd, input logic wr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int kind, input int d, input logic [3:0] noise);
        bit                 ok;
        bit                 fault;
        int                 slot;
        int                 lat;
        int                 s_cyc;
        logic [NUM_DEV-1:0] oh;
        exp_t               x;
        slot = int'((addr >> 12) % NUM_DEV);
        ok   = ((addr >> 28) == 32'hF) && (rd != wr) && (slot < NUM_DEV);
        oh   = NUM_DEV'(1) << slot;
        if (!ok) begin
            fault = 1; lat = 0;
        end else if (kind == K_SILENT || d >= TIMEOUT) begin
            fault = 1; lat = TIMEOUT;
        end else begin
            fault = (kind != K_ACK); lat = d + 1;
        end
        @(posedge clk_in); #1;
        for (int s = 0; s < NUM_DEV; s++)
            dev_rd_data[s*32 +: 32] = (s == slot) ? rdata : $urandom();
        io_addr = addr; io_rd = rd; io_wr = wr; io_wr_data = wdata; io_req = 1'b1;
        s_cyc = cyc + 1;
        x.exp_cyc  = s_cyc + lat;
        x.fault    = fault;
        x.chk_data = fault || rd;
        x.data     = fault ? 32'h0 : rdata;
        sb_q.push_back(x);
        for (int k = 0; k <= lat + 3; k++) begin
            @(posedge clk_in); #1;
            dev_ack = '0;
            dev_fault = '0;
            if (k == lat) io_req = 1'b0;
            if (ok && kind != K_SILENT && k == d) begin
                dev_ack[slot]   = (kind != K_FAULT);
                dev_fault[slot] = (kind != K_ACK);
            end
            if (k == 1) dev_ack = dev_ack | (noise & ~oh);
            if (k == 2) dev_fault = dev_fault | (noise & ~oh);
            @(negedge clk_in);
            if (ok && k < lat) begin
                chk("dev_sel", 64'(dev_sel), 64'(oh));
                if (k == 0) begin
                    chk("dev_rd", 64'(dev_rd), 64'(rd));
                    chk("dev_wr", 64'(dev_wr), 64'(wr));
                    chk("dev_addr", 64'(dev_addr), 64'(addr));
                    chk("dev_wr_data", 64'(dev_wr_data), 64'(wdata));
                end
            end else begin
                chk("dev_sel_off", 64'({dev_sel, dev_rd, dev_wr}), 64'(0));
            end
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, 64'({io_ack, io_ack_fault, dev_sel, dev_rd, dev_wr}), 64'(0));
        chk(name, 64'({io_rd_data, dev_addr}), 64'(0));
        chk(name, 64'(dev_wr_data), 64'(0));
    endtask

    task automatic apply_reset();
        @(posedge clk_in); #1;
        reset_in = 1'b0; io_req = 1'b0; dev_ack = '0; dev_fault = '0;
        repeat (2) @(posedge clk_in);
        #1 chk_all_zero("reset_outs");
        @(posedge clk_in); #1;
        reset_in = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic        r;
        logic        w;
        int          sel;
        apply_reset();
        // Read slot 2 with a late device ack.
        do_txn(32'hF000_2010, 1'b1, 1'b0, 32'h0, 32'h1234_5678, K_ACK, 4, 4'b0000);
        // Write slot 0, first-cycle ack, from a clean reset.
        apply_reset();
        do_txn(32'hF000_0004, 1'b0, 1'b1, 32'hCAFE_F00D, 32'h5555_AAAA, K_ACK, 0, 4'b0000);
        chk("wr_leaves_rd_data", 64'(io_rd_data), 64'(0));
        // Decode faults.
        do_txn(32'h8000_0000, 1'b1, 1'b0, 32'h0, 32'h1111_1111, K_ACK, 0, 4'b0000);
        do_txn(32'hF000_1000, 1'b1, 1'b1, 32'h0, 32'h2222_2222, K_ACK, 0, 4'b0000);
        // Timeout with an unselected slot pulsing ack.
        do_txn(32'hF000_0100, 1'b1, 1'b0, 32'h0, 32'h3333_3333, K_SILENT, 0, 4'b1000);
        // Simultaneous ack and fault on the selected slot.
        do_txn(32'hF000_1020, 1'b1, 1'b0, 32'h0, 32'h4444_4444, K_BOTH, 2, 4'b0000);

        for (int i = 0; i < 150; i++) begin
            a = $urandom();
            if ($urandom_range(0, 4) != 0) a[31:28] = 4'hF;
            sel = $urandom_range(0, 9);
            if (sel == 0) begin r = 1'b1; w = 1'b1; end
            else if (sel == 1) begin r = 1'b0; w = 1'b0; end
            else begin r = 1'($urandom_range(0, 1)); w = !r; end
            do_txn(a, r, w, $urandom(), $urandom(), $urandom_range(0, 3),
                   $urandom_range(0, TIMEOUT + 2), 4'($urandom_range(0, 15)));
        end

        // Abort in the second ACCESS cycle.
        @(posedge clk_in); #1;
        io_addr = 32'hF000_3000; io_rd = 1'b1; io_wr = 1'b0; io_req = 1'b1;
        @(posedge clk_in); #1;
        @(posedge clk_in); #1;
        io_req = 1'b0;
        @(negedge clk_in);
        chk("abort_sel_held", 64'(dev_sel), 64'(4'b1000));
        @(posedge clk_in); #1;
        @(negedge clk_in);
        chk("abort_sel_drop", 64'({dev_sel, dev_rd}), 64'(0));
        repeat (4) @(posedge clk_in);

        // Asynchronous reset in the middle of an access.
        @(posedge clk_in); #1;
        io_addr = 32'hF000_1008; io_rd = 1'b0; io_wr = 1'b1; io_wr_data = 32'hDEAD_BEEF; io_req = 1'b1;
        @(posedge clk_in); #1;
        @(negedge clk_in);
        chk("pre_reset_sel", 64'(dev_sel), 64'(4'b0010));
        #2 reset_in = 1'b0; io_req = 1'b0;
        #1 chk_all_zero("async_reset_outs");
        @(posedge clk_in); #1;
        @(posedge clk_in); #1;
        reset_in = 1'b1;
        do_txn(32'hF000_3044, 1'b1, 1'b0, 32'h0, 32'h0BAD_F00D, K_ACK, 1, 4'b0000);

        repeat (5) @(posedge clk_in);
        chk("sb_empty", 64'(sb_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
